cmos_capture_crop: RTL and testbench

- Parametrised successor to the camera capture/tailor pair: one block that captures a DVP camera byte stream, discards start-up frames, assembles pixels of 1 or 2 bytes, and centre-crops the frame to the LCD resolution.
- Sits between the sensor pins and the SDRAM write FIFO.
- Emits cropped pixels with valid, delayed frame/line syncs, the buffer geometry, and capture status.

---
 rtl/cmos_capture_crop.sv | 178 +++++++++++++++++
 tb/tb_cmos_capture_crop.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_capture_crop.sv
// DVP camera capture: skips settling frames, packs 1- or 2-beat pixels and centre-crops to the display window.
// Pixel/sync outputs trail the sensor pins by two cam_pclk edges; no backpressure, the sensor free-runs.
module cmos_capture_crop #(
  parameter int DATA_W     = 8,
  parameter int PIX_BYTES  = 2,
  parameter int SENS_H     = 640,
  parameter int SENS_V     = 480,
  parameter int FRAME_SKIP = 10
) (
  input  logic                          cam_pclk,
  input  logic                          rst,
  input  logic                          cam_vsync,
  input  logic                          cam_href,
  input  logic [DATA_W-1:0]             cam_data,
  input  logic [10:0]                   h_disp,
  input  logic [10:0]                   v_disp,
  output logic [10:0]                   h_pixel,
  output logic [10:0]                   v_pixel,
  output logic [27:0]                   sdram_addr_max,
  output logic                          frame_vsync,
  output logic                          frame_href,
  output logic                          pix_valid,
  output logic [DATA_W*PIX_BYTES-1:0]   pix_data,
  output logic [15:0]                   frame_cnt,
  output logic                          line_err
);

  localparam int              PW       = DATA_W * PIX_BYTES;
  localparam int              SKW      = (FRAME_SKIP < 1) ? 1 : $clog2(FRAME_SKIP + 1);
  localparam logic [SKW-1:0]  SKIP_MAX = SKW'(FRAME_SKIP);
  localparam logic [10:0]     SH       = 11'(SENS_H);
  localparam logic [10:0]     SV       = 11'(SENS_V);
  localparam logic [10:0]     CNT_MAX  = 11'd2047;

  logic              vs1, hr1, vs1_d, hr1_d;
  logic [DATA_W-1:0] d1;
  logic              vs_rise, href_fall;

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      vs1   <= 1'b0;
      hr1   <= 1'b0;
      vs1_d <= 1'b0;
      hr1_d <= 1'b0;
      d1    <= '0;
    end else begin
      vs1   <= cam_vsync;
      hr1   <= cam_href;
      vs1_d <= vs1;
      hr1_d <= hr1;
      d1    <= cam_data;
    end
  end

  assign vs_rise   = vs1 & ~vs1_d;
  assign href_fall = ~hr1 & hr1_d;

  logic [SKW-1:0] skip_cnt;
  logic           cap_en, cap_en_eff;

  // Capture opens on the rise after FRAME_SKIP full frames have been seen.
  assign cap_en_eff = cap_en | (vs_rise && skip_cnt == SKIP_MAX);

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      skip_cnt  <= '0;
      cap_en    <= 1'b0;
      frame_cnt <= '0;
    end else if (vs_rise) begin
      if (skip_cnt != SKIP_MAX) skip_cnt <= skip_cnt + SKW'(1);
      cap_en <= cap_en_eff;
      if (cap_en) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  logic [10:0] hp_new, vp_new, ho_new, vo_new, h_off, v_off;
  logic [21:0] area_new;

  assign hp_new   = (h_disp < SH) ? h_disp : SH;
  assign vp_new   = (v_disp < SV) ? v_disp : SV;
  assign ho_new   = (SH - hp_new) >> 1;
  assign vo_new   = (SV - vp_new) >> 1;
  assign area_new = {11'd0, hp_new} * {11'd0, vp_new};

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      h_pixel        <= '0;
      v_pixel        <= '0;
      h_off          <= '0;
      v_off          <= '0;
      sdram_addr_max <= '0;
    end else if (vs_rise) begin
      h_pixel        <= hp_new;
      v_pixel        <= vp_new;
      h_off          <= ho_new;
      v_off          <= vo_new;
      sdram_addr_max <= {6'd0, area_new};
    end
  end

  // A vsync rise restarts line/frame state so a beat in that same cycle belongs to the new frame.
  logic [10:0] win_hp, win_vp, win_ho, win_vo;
  assign win_hp = vs_rise ? hp_new : h_pixel;
  assign win_vp = vs_rise ? vp_new : v_pixel;
  assign win_ho = vs_rise ? ho_new : h_off;
  assign win_vo = vs_rise ? vo_new : v_off;

  logic          phase, eff_phase, pix_done;
  logic [PW-1:0] pix_word;

  assign eff_phase = phase & ~vs_rise;

  generate
    if (PIX_BYTES == 1) begin : g_one
      assign pix_done = hr1;
      assign pix_word = d1;
    end else begin : g_two
      logic [DATA_W-1:0] upper;
      always_ff @(posedge cam_pclk or posedge rst) begin
        if (rst)                   upper <= '0;
        else if (hr1 && !eff_phase) upper <= d1;
      end
      assign pix_done = hr1 & eff_phase;
      assign pix_word = {upper, d1};
    end
  endgenerate

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst)                  phase <= 1'b0;
    else if (!hr1)            phase <= 1'b0;
    else if (PIX_BYTES == 2)  phase <= ~eff_phase;
    else                      phase <= 1'b0;
  end

  logic [10:0] x_cnt, y_cnt, x_eff, y_eff;
  logic [11:0] x_lim, y_lim;
  logic        in_x, in_y;

  assign x_eff = vs_rise ? 11'd0 : x_cnt;
  assign y_eff = vs_rise ? 11'd0 : y_cnt;
  assign x_lim = {1'b0, win_ho} + {1'b0, win_hp};
  assign y_lim = {1'b0, win_vo} + {1'b0, win_vp};
  assign in_x  = (x_eff >= win_ho) && ({1'b0, x_eff} < x_lim);
  assign in_y  = (y_eff >= win_vo) && ({1'b0, y_eff} < y_lim);

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (!hr1)                             x_cnt <= '0;
      else if (pix_done && x_eff != CNT_MAX) x_cnt <= x_eff + 11'd1;
      else                                  x_cnt <= x_eff;

      if (vs_rise)                               y_cnt <= '0;
      else if (href_fall && y_cnt != CNT_MAX)    y_cnt <= y_cnt + 11'd1;
    end
  end

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      frame_vsync <= 1'b0;
      frame_href  <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      pix_valid   <= pix_done & cap_en_eff & in_x & in_y;
      if (pix_done && cap_en_eff && in_x && in_y) pix_data <= pix_word;
      frame_vsync <= vs1 & cap_en_eff;
      frame_href  <= hr1 & cap_en_eff;
      // The frame-start clear takes priority over a line ending in the same cycle.
      if (vs_rise)                                     line_err <= 1'b0;
      else if (href_fall && (phase || x_cnt != SH))    line_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmos_capture_crop.sv
// Bench: two captures share one sensor stream (RGB565 8x4 skipping 2 frames, RAW8 16x4 skipping none); scoreboard checks pixels and cycle timing.
module tb_cmos_capture_crop;

  logic        clk = 1'b0;
  logic        rst;
  logic        cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic [10:0] h_disp, v_disp;

  logic [10:0] d2_hpix, d2_vpix, d1_hpix, d1_vpix;
  logic [27:0] d2_addr, d1_addr;
  logic        d2_fv, d2_fh, d2_pv, d2_le, d1_fv, d1_fh, d1_pv, d1_le;
  logic [15:0] d2_pd, d2_fc, d1_fc;
  logic [7:0]  d1_pd;

  always #5 clk = ~clk;

  cmos_capture_crop #(.DATA_W(8), .PIX_BYTES(2), .SENS_H(8), .SENS_V(4), .FRAME_SKIP(2)) u_dut2 (
    .cam_pclk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .h_disp(h_disp), .v_disp(v_disp), .h_pixel(d2_hpix), .v_pixel(d2_vpix),
    .sdram_addr_max(d2_addr), .frame_vsync(d2_fv), .frame_href(d2_fh), .pix_valid(d2_pv),
    .pix_data(d2_pd), .frame_cnt(d2_fc), .line_err(d2_le));

  cmos_capture_crop #(.DATA_W(8), .PIX_BYTES(1), .SENS_H(16), .SENS_V(4), .FRAME_SKIP(0)) u_dut1 (
    .cam_pclk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .h_disp(h_disp), .v_disp(v_disp), .h_pixel(d1_hpix), .v_pixel(d1_vpix),
    .sdram_addr_max(d1_addr), .frame_vsync(d1_fv), .frame_href(d1_fh), .pix_valid(d1_pv),
    .pix_data(d1_pd), .frame_cnt(d1_fc), .line_err(d1_le));

  typedef struct {
    int          cyc;
    logic [15:0] dat;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  int   fr;
  int   hp2, ho2, vp2, vo2, hp1, ho1, vp1, vo1;
  bit   cap2, cap1, err2, err1;
  int   vc2, hc2, vc1, hc1, hbeats;
  logic [7:0] prev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_win(int x, int y, int ho, int hp, int vo, int vp);
    return (x >= ho) && (x < ho + hp) && (y >= vo) && (y < vo + vp);
  endfunction

  task automatic sample();
    exp_t e;
    if (d2_pv) begin
      check("pv2_expected", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("pix2_dat", d2_pd, e.dat);
        check("pix2_cyc", cyc, e.cyc);
      end
    end
    if (d1_pv) begin
      check("pv1_expected", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("pix1_dat", d1_pd, e.dat);
        check("pix1_cyc", cyc, e.cyc);
      end
    end
    if (d2_fv) vc2++;
    if (d2_fh) hc2++;
    if (d1_fv) vc1++;
    if (d1_fh) hc1++;
  endtask

  task automatic beat_step(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    sample();
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
  endtask

  task automatic send_line(input int nb, input int y, input int tail);
    logic [7:0] d;
    for (int b = 0; b < nb; b++) begin
      d = 8'($urandom_range(0, 255));
      beat_step(1'b0, 1'b1, d);
      if ((b % 2 == 1) && cap2 && in_win(b / 2, y, ho2, hp2, vo2, vp2))
        q2.push_back('{cyc + 2, {prev, d}});
      if (cap1 && in_win(b, y, ho1, hp1, vo1, vp1))
        q1.push_back('{cyc + 2, {8'd0, d}});
      prev = d;
      hbeats++;
    end
    if ((nb % 2 != 0) || (nb / 2 != 8)) err2 = 1'b1;
    if (nb != 16) err1 = 1'b1;
    repeat (tail) beat_step(1'b0, 1'b0, 8'd0);
  endtask

  task automatic frame_start(input int hd, input int vd);
    h_disp = 11'(hd);
    v_disp = 11'(vd);
    fr++;
    cap2 = (fr > 2);
    cap1 = (fr > 0);
    hp2 = (hd < 8) ? hd : 8;   ho2 = (8 - hp2) / 2;
    hp1 = (hd < 16) ? hd : 16; ho1 = (16 - hp1) / 2;
    vp2 = (vd < 4) ? vd : 4;   vo2 = (4 - vp2) / 2;
    vp1 = vp2;                 vo1 = vo2;
    vc2 = 0; hc2 = 0; vc1 = 0; hc1 = 0; hbeats = 0; err2 = 1'b0; err1 = 1'b0;
    repeat (3) beat_step(1'b1, 1'b0, 8'd0);
    repeat (3) beat_step(1'b0, 1'b0, 8'd0);
    check("hpix2", d2_hpix, hp2);
    check("vpix2", d2_vpix, vp2);
    check("addr2", d2_addr, hp2 * vp2);
    check("hpix1", d1_hpix, hp1);
    check("addr1", d1_addr, hp1 * vp1);
    check("lerr2_clr", d2_le, 0);
    check("lerr1_clr", d1_le, 0);
    check("fcnt2", d2_fc, (fr > 3) ? fr - 3 : 0);
    check("fcnt1", d1_fc, fr - 1);
  endtask

  task automatic frame_end();
    repeat (2) beat_step(1'b0, 1'b0, 8'd0);
    check("vsync2_cycles", vc2, cap2 ? 3 : 0);
    check("href2_cycles",  hc2, cap2 ? hbeats : 0);
    check("vsync1_cycles", vc1, 3);
    check("href1_cycles",  hc1, hbeats);
    check("lerr2", d2_le, err2);
    check("lerr1", d1_le, err1);
    check("q2_drained", q2.size(), 0);
    check("q1_drained", q1.size(), 0);
  endtask

  task automatic full_frame(input int hd, input int vd, input int odd_line, input int mid_hd);
    frame_start(hd, vd);
    for (int y = 0; y < 4; y++) begin
      if (y == 1 && mid_hd >= 0) h_disp = 11'(mid_hd);
      send_line((y == odd_line) ? 15 : 16, y, 4);
    end
    frame_end();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pv2"},   d2_pv, 0);
    check({tag, "_pd2"},   d2_pd, 0);
    check({tag, "_fv2"},   d2_fv, 0);
    check({tag, "_fh2"},   d2_fh, 0);
    check({tag, "_fc2"},   d2_fc, 0);
    check({tag, "_hp2"},   d2_hpix, 0);
    check({tag, "_vp2"},   d2_vpix, 0);
    check({tag, "_addr2"}, d2_addr, 0);
    check({tag, "_le2"},   d2_le, 0);
    check({tag, "_pd1"},   d1_pd, 0);
    check({tag, "_fc1"},   d1_fc, 0);
    check({tag, "_fh1"},   d1_fh, 0);
  endtask

  initial begin
    rst = 1'b1;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = 8'd0;
    h_disp    = 11'd8;
    v_disp    = 11'd8;
    prev      = 8'd0;
    fr        = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (3) beat_step(1'b0, 1'b0, 8'd0);

    // Frames 1-2 skipped by the RGB565 capture, frame 3 captured in full, frame_cnt steps at frame 4.
    full_frame(8, 8, -1, -1);
    full_frame(8, 8, -1, -1);
    full_frame(8, 8, -1, -1);
    full_frame(8, 8, -1, -1);
    // Centre crop, then an oversize request that clamps to the sensor.
    full_frame(4, 2, -1, -1);
    full_frame(2000, 9, -1, -1);
    // Odd-length line plus a mid-frame width change that must not take effect.
    full_frame(8, 4, 1, 2);
    // Zero-width window: no pixels, syncs still flow.
    full_frame(0, 4, -1, -1);

    // Reset in the middle of a line.
    frame_start(8, 4);
    send_line(16, 0, 4);
    send_line(5, 1, 0);
    @(negedge clk);
    sample();
    rst      = 1'b1;
    cam_href = 1'b0;
    cam_data = 8'd0;
    #1;
    check_zero("midrst");
    q2.delete();
    q1.delete();
    repeat (3) beat_step(1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    fr  = 0;
    repeat (3) beat_step(1'b0, 1'b0, 8'd0);

    full_frame(8, 4, -1, -1);
    full_frame(8, 4, -1, -1);
    full_frame(6, 4, -1, -1);
    full_frame(6, 4, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
